// File: rtl/ime_mv_fetch_pkg.sv
// Shared encoder defines for the IME MV fetch slice: block count, MV word width,
// FSM encoding and the z-scan to raster address mapping.
package ime_mv_fetch_pkg;

   localparam int BLK_NUM   = 64;
   localparam int MV_WORD_W = 13;
   localparam int IDX_W     = 6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } fetch_state_t;

   // De-interleave z-scan bits: odd bits form blk_y, even bits form blk_x.
   function automatic logic [IDX_W-1:0] z_to_raster(input logic [IDX_W-1:0] z);
      return {z[5], z[3], z[1], z[4], z[2], z[0]};
   endfunction

endpackage

// File: rtl/ime_mv_fifo_2.sv
// Two-entry FIFO holding formatted MV entries between the RAM read stage and FME.
module ime_mv_fifo_2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head entry is held until popped, keeping outputs stable during a stall.
   assign dout = mem[rd_ptr];

endmodule

// File: rtl/ime_mv_fetch.sv
// Fetches one 64x64 CTU of integer-pel MVs from the MV RAM in z-scan order,
// converts them to quarter-pel and hands them to FME through a 2-entry FIFO.
module ime_mv_fetch
   import ime_mv_fetch_pkg::*;
#(
   parameter int MVX_W = 7,
   parameter int MVY_W = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [IDX_W-1:0]       adr_o,
   output logic                   rd_ena_o,
   input  logic [MV_WORD_W-1:0]   rd_dat_i,
   output logic                   mv_val_o,
   input  logic                   mv_rdy_i,
   output logic [IDX_W-1:0]       mv_idx_o,
   output logic signed [MVX_W+1:0] mv_x_o,
   output logic signed [MVY_W+1:0] mv_y_o,
   output logic                   mv_last_o
);

   localparam int ENT_W = IDX_W + (MVX_W + 2) + (MVY_W + 2) + 1;

   fetch_state_t     state, state_nxt;
   logic [IDX_W-1:0] rd_idx;
   logic [IDX_W-1:0] cap_idx;
   logic [IDX_W-1:0] adr_hold;
   logic             in_flight;
   logic             issue;
   logic             pop;
   logic             done_q;
   logic [1:0]       fifo_count;
   logic [2:0]       occ;
   logic [ENT_W-1:0] fifo_din;
   logic [ENT_W-1:0] fifo_dout;

   assign pop      = mv_val_o & mv_rdy_i;
   assign mv_val_o = (fifo_count != 2'd0);
   // Slots already committed after this cycle's pop; a new read may only claim a free one.
   assign occ      = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_i) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (occ < 3'd2) begin
               issue = 1'b1;
               if (rd_idx == IDX_W'(BLK_NUM - 1)) state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (pop && mv_last_o) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         rd_idx    <= '0;
         cap_idx   <= '0;
         adr_hold  <= '0;
         in_flight <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_flight <= issue;
         adr_hold  <= adr_o;
         done_q    <= (state == S_DRAIN) && pop && mv_last_o;
         if (issue) begin
            rd_idx  <= rd_idx + 1'b1;
            cap_idx <= rd_idx;
         end
      end
   end

   assign rd_ena_o = ~issue;
   assign adr_o    = issue ? z_to_raster(rd_idx) : adr_hold;
   assign busy_o   = (state != S_IDLE);
   assign done_o   = done_q;

   assign fifo_din = {cap_idx,
                      rd_dat_i[MV_WORD_W-1:MVY_W], 2'b00,
                      rd_dat_i[MVY_W-1:0], 2'b00,
                      (cap_idx == IDX_W'(BLK_NUM - 1))};

   ime_mv_fifo_2 #(
      .W (ENT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_flight),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign {mv_idx_o, mv_x_o, mv_y_o, mv_last_o} = fifo_dout;

endmodule

// File: tb/tb_ime_mv_fetch.sv
// Randomized bench for ime_mv_fetch with a z-scan expectation queue and RAM model.
module tb_ime_mv_fetch;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_i = 1'b0;
   logic              busy_o, done_o, rd_ena_o, mv_val_o, mv_last_o;
   logic [5:0]        adr_o, mv_idx_o;
   logic [12:0]       rd_dat_i = '0;
   logic              mv_rdy_i = 1'b1;
   logic signed [8:0] mv_x_o;
   logic signed [7:0] mv_y_o;

   ime_mv_fetch #(.MVX_W(7), .MVY_W(6)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
      .adr_o(adr_o), .rd_ena_o(rd_ena_o), .rd_dat_i(rd_dat_i),
      .mv_val_o(mv_val_o), .mv_rdy_i(mv_rdy_i), .mv_idx_o(mv_idx_o),
      .mv_x_o(mv_x_o), .mv_y_o(mv_y_o), .mv_last_o(mv_last_o)
   );

   always #5 clk = ~clk;

   typedef struct {int idx; int x; int y; int last;} exp_t;
   exp_t        q[$];
   logic [12:0] ram [64];
   int n_tests = 0, n_fail = 0;
   int hs = 0, done_cnt = 0, val_cycles = 0, reads_total = 0, pops_total = 0;
   bit rdy_rand = 1'b0, pin_on = 1'b0, stall_prev = 1'b0;
   int prev_idx, prev_x, prev_y, prev_last;

   // synchronous RAM: data appears the cycle after a low read enable
   always @(posedge clk) if (!rd_ena_o) rd_dat_i <= ram[adr_o];

   initial forever begin
      @(posedge clk); #1;
      mv_rdy_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int raster_of(input int z);
      int bx, by;
      bx = (z % 2) + 2 * ((z / 4) % 2) + 4 * ((z / 16) % 2);
      by = ((z / 2) % 2) + 2 * ((z / 8) % 2) + 4 * ((z / 32) % 2);
      return by * 8 + bx;
   endfunction

   task automatic build_exp();
      exp_t e;
      int   xs, ys;
      q.delete();
      for (int z = 0; z < 64; z++) begin
         xs = int'(ram[raster_of(z)][12:6]); if (xs >= 64) xs -= 128;
         ys = int'(ram[raster_of(z)][5:0]);  if (ys >= 32) ys -= 64;
         e.idx = z; e.x = xs * 4; e.y = ys * 4; e.last = (z == 63) ? 1 : 0;
         q.push_back(e);
      end
      hs = 0; val_cycles = 0; reads_total = 0; pops_total = 0;
   endtask

   always @(negedge clk) begin
      if (rst) stall_prev = 1'b0;
      else begin
         if (!rd_ena_o) begin
            check("issue_occ_lt2",
                  ((reads_total - pops_total - ((mv_val_o && mv_rdy_i) ? 1 : 0)) < 2) ? 1 : 0, 1);
            reads_total++;
         end
         if (stall_prev && mv_val_o)
            check("stall_stable", (int'(mv_idx_o) == prev_idx && int'(mv_x_o) == prev_x &&
                                   int'(mv_y_o) == prev_y && int'(mv_last_o) == prev_last) ? 1 : 0, 1);
         if (mv_val_o) begin
            val_cycles++;
            if (q.size() == 0) check("unexpected_mv", 1, 0);
            else begin
               check("mv_idx", int'(mv_idx_o), q[0].idx);
               check("mv_x", int'(mv_x_o), q[0].x);
               check("mv_y", int'(mv_y_o), q[0].y);
               check("mv_last", int'(mv_last_o), q[0].last);
               if (pin_on && mv_idx_o == 6'd3) begin
                  check("pin_idx3_x", int'(mv_x_o), -4);
                  check("pin_idx3_y", int'(mv_y_o), -4);
               end
               if (pin_on && mv_idx_o == 6'd63) begin
                  check("pin_idx63_last", int'(mv_last_o), 1);
                  check("pin_idx63_x", int'(mv_x_o), 252);
                  check("pin_idx63_y", int'(mv_y_o), -128);
               end
               if (mv_rdy_i) begin
                  void'(q.pop_front());
                  hs++; pops_total++;
               end
            end
         end
         if (done_o) begin
            check("done_after_last", hs, 64);
            done_cnt++;
         end
         stall_prev = mv_val_o && !mv_rdy_i;
         prev_idx = int'(mv_idx_o); prev_x = int'(mv_x_o);
         prev_y = int'(mv_y_o); prev_last = int'(mv_last_o);
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, int'(busy_o), 0);
      check({tag, "_done"}, int'(done_o), 0);
      check({tag, "_rd_ena"}, int'(rd_ena_o), 1);
      check({tag, "_adr"}, int'(adr_o), 0);
      check({tag, "_val"}, int'(mv_val_o), 0);
      check({tag, "_idx"}, int'(mv_idx_o), 0);
      check({tag, "_x"}, int'(mv_x_o), 0);
      check({tag, "_y"}, int'(mv_y_o), 0);
      check({tag, "_last"}, int'(mv_last_o), 0);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
   endtask

   task automatic wait_done(input int base_cnt);
      int k = 0;
      while (done_cnt == base_cnt && k < 3000) begin @(posedge clk); #2; k++; end
      if (done_cnt == base_cnt) check("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int k, d0;
      repeat (3) @(posedge clk);
      #2 check_reset_outputs("reset");
      #1 rst = 1'b0;

      // A: word[a]=a, ready held high
      for (int a = 0; a < 64; a++) ram[a] = 13'(a);
      build_exp(); rdy_rand = 1'b0; pin_on = 1'b0;
      d0 = done_cnt;
      pulse_start();
      check("busy_after_start", int'(busy_o), 1);
      k = 0;
      while (!mv_val_o && k < 10) begin @(posedge clk); #1; k++; end
      check("first_val_latency", k, 2);
      wait_done(d0);
      check("A_handshakes", hs, 64);
      check("A_val_cycles", val_cycles, 64);
      check("A_done_once", done_cnt - d0, 1);
      check("A_idle_busy", int'(busy_o), 0);

      // B: random words with pinned entries, random ready, restart ignored
      for (int a = 0; a < 64; a++) ram[a] = 13'($urandom);
      ram[9] = 13'h1FFF; ram[63] = 13'h0FE0;
      build_exp(); rdy_rand = 1'b1; pin_on = 1'b1;
      d0 = done_cnt;
      pulse_start();
      repeat (9) @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      wait_done(d0);
      check("B_handshakes", hs, 64);
      check("B_done_once", done_cnt - d0, 1);
      check("B_queue_empty", q.size(), 0);

      // C: reset after 20 MVs, then a full fresh fetch
      for (int a = 0; a < 64; a++) ram[a] = 13'($urandom);
      build_exp(); rdy_rand = 1'b0; pin_on = 1'b0;
      d0 = done_cnt;
      pulse_start();
      k = 0;
      while (hs < 20 && k < 200) begin @(posedge clk); #2; k++; end
      check("C_reach_20", (hs >= 20) ? 1 : 0, 1);
      @(posedge clk); #1 rst = 1'b1;
      #1 check_reset_outputs("abort");
      repeat (2) @(posedge clk);
      check("C_no_done", done_cnt - d0, 0);
      #1 rst = 1'b0;
      rdy_rand = 1'b1;
      build_exp();
      pulse_start();
      k = 0;
      while (!mv_val_o && k < 20) begin @(posedge clk); #1; k++; end
      check("C_first_idx", int'(mv_idx_o), 0);
      wait_done(d0);
      check("C_handshakes", hs, 64);
      check("C_done_once", done_cnt - d0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
